// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared lane-index type and wrapping increment for round-robin
// pointers (used by dispatch_round_robin and reusable by put_in_order).
// Contents: lane_idx_t (default 4-lane width), next_lane(ptr, n).
package dispatch_pkg;

  localparam int unsigned N_LANES_DFLT = 4;
  localparam int unsigned LANE_W_DFLT  = $clog2(N_LANES_DFLT);

  typedef logic [LANE_W_DFLT-1:0] lane_idx_t;

  // Wrapping increment: n-1 -> 0. Works for any n >= 2, not just powers of two.
  function automatic int unsigned next_lane(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pointer.sv
// rr_pointer: wrapping lane pointer, advances by one on en_i, wraps N-1 -> 0.
// Ports: clk, rst (sync, active-high), en_i (advance), ptr_o (current lane).
// ptr_o is a pure register output.
module rr_pointer
  import dispatch_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = W'(next_lane(32'(ptr_q), N));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dispatch_round_robin.sv
// dispatch_round_robin: issues an in-order stream strictly round-robin to n_inputs
// single-item lanes; 1-cycle issue latency; stalls (up_rdy=0) while the next lane is busy.
// Ports: up_vld/up_rdy/up_data in, down_vlds/down_data issue, done_vlds completions,
// outstanding in-flight count, err sticky protocol error.
module dispatch_round_robin
  import dispatch_pkg::*;
#(
  parameter int unsigned width    = 16,
  parameter int unsigned n_inputs = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            up_vld,
  output logic                            up_rdy,
  input  logic [width-1:0]                up_data,
  output logic [n_inputs-1:0]             down_vlds,
  output logic [width-1:0]                down_data,
  input  logic [n_inputs-1:0]             done_vlds,
  output logic [$clog2(n_inputs+1)-1:0]   outstanding,
  output logic                            err
);

  localparam int unsigned LW = $clog2(n_inputs);
  localparam int unsigned OW = $clog2(n_inputs + 1);

  logic [LW-1:0]       ptr;
  logic                accept;
  logic [n_inputs-1:0] lane_oh;
  logic [n_inputs-1:0] done_ok, done_bad;
  logic [OW-1:0]       done_cnt;

  logic [n_inputs-1:0] busy_q, busy_d;
  logic [n_inputs-1:0] down_vlds_q, down_vlds_d;
  logic [width-1:0]    down_data_q, down_data_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic                err_q, err_d;

  rr_pointer #(.N(n_inputs)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (accept),
    .ptr_o (ptr)
  );

  // Ready depends only on registered state; no combinational path from up_vld or done_vlds.
  // Strict order: never skip to a free lane, put_in_order expects the fixed rotation.
  assign up_rdy  = ~busy_q[ptr];
  assign accept  = up_vld & up_rdy;
  assign lane_oh = n_inputs'(1) << ptr;

  // A done on an idle lane is spurious or duplicate: flag it and otherwise ignore it.
  assign done_ok  = done_vlds & busy_q;
  assign done_bad = done_vlds & ~busy_q;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < int'(n_inputs); i++) begin
      if (done_ok[i]) done_cnt = done_cnt + OW'(1);
    end
  end

  always_comb begin
    // The accepted lane is idle this cycle, so clearing dones before setting it is safe.
    busy_d        = (busy_q & ~done_ok) | (accept ? lane_oh : '0);
    down_vlds_d   = accept ? lane_oh : '0;
    down_data_d   = accept ? up_data : down_data_q;
    outstanding_d = outstanding_q + OW'(accept) - done_cnt;
    err_d         = err_q | (|done_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      down_vlds_q   <= '0;
      down_data_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      down_vlds_q   <= down_vlds_d;
      down_data_q   <= down_data_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign down_vlds   = down_vlds_q;
  assign down_data   = down_data_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule
